// File: rtl/modn_down_counter.sv
// Mod-MOD down counter with load, enable and cascadable borrow; MODN_DOWN_SATURATE_EN makes it stop at 0 instead of wrapping.
// Latency: Q and TC are registered (1 cycle after the sampling edge); BO is combinational from EN and Q.
// Backpressure: none; EN and LD are sampled every CLK edge, and BO feeds EN of the next stage.
module modn_down_counter #(
    parameter int WIDTH = 3,
    parameter int MOD   = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             TC
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_DEC,
        ACT_WRAP,
        ACT_RECOVER
    } act_t;

    act_t             act;
    logic             q_illegal;
    logic             q_zero;
    logic [WIDTH-1:0] load_val;

    // Out-of-range states only exist when MOD < 2**WIDTH; the compare folds to 0 otherwise.
    assign q_illegal = ({1'b0, Q} >= MOD_W);
    assign q_zero    = (Q == '0);
    assign load_val  = ({1'b0, D} >= MOD_W) ? TOP : D;
    assign BO        = EN & q_zero;

    always_comb begin
        act = ACT_HOLD;
        if (q_illegal) begin
            act = ACT_RECOVER;
        end else if (LD) begin
            act = ACT_LOAD;
        end else if (EN) begin
            if (!q_zero) begin
                act = ACT_DEC;
            end else begin
`ifdef MODN_DOWN_SATURATE_EN
                act = ACT_HOLD;
`else
                act = ACT_WRAP;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q  <= '0;
            TC <= 1'b0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    Q  <= load_val;
                    TC <= 1'b0;
                end
                ACT_DEC: begin
                    Q  <= Q - 1'b1;
                    TC <= 1'b0;
                end
                ACT_WRAP: begin
                    Q  <= TOP;
                    TC <= 1'b1;
                end
                ACT_RECOVER: begin
                    Q  <= '0;
                    TC <= 1'b0;
                end
                default: begin
                    Q  <= Q;
                    TC <= 1'b0;
                end
            endcase
        end
    end

endmodule
